// File: rtl/branch_update_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_update_queue_if : enqueue/resolve/update bundle of the update queue |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface branch_update_queue_if #(
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             enq_valid;
  logic             enq_ready;
  logic [9:0]       enq_pc;
  logic [1:0]       enq_counter;
  logic             res_valid;
  logic             res_taken;
  logic             flush;
  logic             upd_valid;
  logic [9:0]       upd_pc;
  logic             upd_taken;
  logic [1:0]       upd_counter;
  logic             upd_mispredict;
  logic             res_err;
  logic [PTR_W:0]   occupancy;

  // master is the pipeline/predictor side, slave is the queue itself
  modport master (
    output enq_valid, enq_pc, enq_counter, res_valid, res_taken, flush,
    input  enq_ready, upd_valid, upd_pc, upd_taken, upd_counter,
           upd_mispredict, res_err, occupancy
  );

  modport slave (
    input  enq_valid, enq_pc, enq_counter, res_valid, res_taken, flush,
    output enq_ready, upd_valid, upd_pc, upd_taken, upd_counter,
           upd_mispredict, res_err, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/branch_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_update_queue : in-order PC/counter queue feeding predictor updates  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module branch_update_queue #(
  parameter int DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  branch_update_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0]   c_FULL      = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);
  localparam logic [1:0]       c_CTR_RESET = 2'b01;

  logic [9:0]       r_mem_pc  [DEPTH];
  logic [1:0]       r_mem_ctr [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [PTR_W:0]   r_cnt;

  logic             r_upd_valid;
  logic [9:0]       r_upd_pc;
  logic             r_upd_taken;
  logic [1:0]       r_upd_counter;
  logic             r_upd_mispredict;
  logic             r_res_err;

  logic             w_ready;
  logic             w_empty;
  logic             w_enq_fire;
  logic             w_res_fire;
  logic             w_res_err;
  logic [9:0]       w_head_pc;
  logic [1:0]       w_head_ctr;

  // Ready looks only at the registered count, so a full queue never admits
  // an entry on the strength of a same-cycle pop.
  assign w_ready    = (r_cnt != c_FULL);
  assign w_empty    = (r_cnt == '0);
  assign w_enq_fire = bus.enq_valid & w_ready & ~bus.flush;
  assign w_res_fire = bus.res_valid & ~w_empty & ~bus.flush;
  assign w_res_err  = bus.res_valid &  w_empty & ~bus.flush;
  assign w_head_pc  = r_mem_pc[r_rp];
  assign w_head_ctr = r_mem_ctr[r_rp];

  // Entry storage is never read while cnt says it is stale, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem_pc[r_wp]  <= bus.enq_pc;
      r_mem_ctr[r_wp] <= bus.enq_counter;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (bus.flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_enq_fire) r_wp <= r_wp + c_PTR_ONE;
      if (w_res_fire) r_rp <= r_rp + c_PTR_ONE;
      case ({w_enq_fire, w_res_fire})
        2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Update payload holds between strobes; only the strobe itself drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_taken      <= 1'b0;
      r_upd_counter    <= c_CTR_RESET;
      r_upd_mispredict <= 1'b0;
      r_res_err        <= 1'b0;
    end else begin
      r_upd_valid <= w_res_fire;
      r_res_err   <= w_res_err;
      if (w_res_fire) begin
        r_upd_pc         <= w_head_pc;
        r_upd_taken      <= bus.res_taken;
        r_upd_counter    <= w_head_ctr;
        r_upd_mispredict <= w_head_ctr[1] ^ bus.res_taken;
      end
    end
  end

  assign bus.enq_ready      = w_ready;
  assign bus.upd_valid      = r_upd_valid;
  assign bus.upd_pc         = r_upd_pc;
  assign bus.upd_taken      = r_upd_taken;
  assign bus.upd_counter    = r_upd_counter;
  assign bus.upd_mispredict = r_upd_mispredict;
  assign bus.res_err        = r_res_err;
  assign bus.occupancy      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_update_queue : directed vector bench for branch_update_queue     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_branch_update_queue;
  localparam int DEPTH = 8;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  branch_update_queue_if #(.DEPTH(DEPTH)) bus ();

  branch_update_queue #(.DEPTH(DEPTH)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic [9:0] epc;
    logic [1:0] ectr;
    logic       rv;
    logic       rt;
    logic       fl;
    logic       xuv;
    logic [9:0] xpc;
    logic       xt;
    logic [1:0] xc;
    logic       xm;
    logic       xerr;
    logic [3:0] xocc;
    logic       xrdy;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic ev, logic [9:0] epc, logic [1:0] ectr,
                              logic rv, logic rt, logic fl,
                              logic xuv, logic [9:0] xpc, logic xt,
                              logic [1:0] xc, logic xm, logic xerr,
                              logic [3:0] xocc, logic xrdy);
    vec_t v;
    v.ev = ev; v.epc = epc; v.ectr = ectr; v.rv = rv; v.rt = rt; v.fl = fl;
    v.xuv = xuv; v.xpc = xpc; v.xt = xt; v.xc = xc; v.xm = xm;
    v.xerr = xerr; v.xocc = xocc; v.xrdy = xrdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [9:0] epc, input logic [1:0] ectr,
                       input logic rv, input logic rt, input logic fl);
    bus.enq_valid   = ev;
    bus.enq_pc      = epc;
    bus.enq_counter = ectr;
    bus.res_valid   = rv;
    bus.res_taken   = rt;
    bus.flush       = fl;
  endtask

  // advance one edge; outputs are then sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 10'h0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " upd_valid"},      32'(bus.upd_valid),      32'd0);
    chk({tag, " upd_pc"},         32'(bus.upd_pc),         32'd0);
    chk({tag, " upd_taken"},      32'(bus.upd_taken),      32'd0);
    chk({tag, " upd_counter"},    32'(bus.upd_counter),    32'd1);
    chk({tag, " upd_mispredict"}, 32'(bus.upd_mispredict), 32'd0);
    chk({tag, " res_err"},        32'(bus.res_err),        32'd0);
    chk({tag, " occupancy"},      32'(bus.occupancy),      32'd0);
    chk({tag, " enq_ready"},      32'(bus.enq_ready),      32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    idle();

    //        ev  epc     ectr   rv  rt  fl | uv  pc      t  c      m  err occ rdy
    tbl[0]  = mk(1, 10'h005, 2'b01, 0, 0, 0,  0, 10'h000, 0, 2'b01, 0, 0, 1, 1);
    tbl[1]  = mk(1, 10'h3FF, 2'b11, 0, 0, 0,  0, 10'h000, 0, 2'b01, 0, 0, 2, 1);
    tbl[2]  = mk(0, 10'h000, 2'b00, 1, 1, 0,  1, 10'h005, 1, 2'b01, 1, 0, 1, 1);
    tbl[3]  = mk(0, 10'h000, 2'b00, 0, 0, 0,  0, 10'h005, 1, 2'b01, 1, 0, 1, 1);
    tbl[4]  = mk(0, 10'h000, 2'b00, 1, 1, 0,  1, 10'h3FF, 1, 2'b11, 0, 0, 0, 1);
    tbl[5]  = mk(0, 10'h000, 2'b00, 0, 0, 0,  0, 10'h3FF, 1, 2'b11, 0, 0, 0, 1);
    tbl[6]  = mk(0, 10'h000, 2'b00, 1, 0, 0,  0, 10'h3FF, 1, 2'b11, 0, 1, 0, 1);
    tbl[7]  = mk(0, 10'h000, 2'b00, 0, 0, 0,  0, 10'h3FF, 1, 2'b11, 0, 0, 0, 1);
    tbl[8]  = mk(1, 10'h02A, 2'b10, 1, 1, 0,  0, 10'h3FF, 1, 2'b11, 0, 1, 1, 1);
    tbl[9]  = mk(1, 10'h02B, 2'b00, 1, 0, 0,  1, 10'h02A, 0, 2'b10, 1, 0, 1, 1);
    tbl[10] = mk(0, 10'h000, 2'b00, 1, 0, 0,  1, 10'h02B, 0, 2'b00, 0, 0, 0, 1);
    tbl[11] = mk(1, 10'h1AA, 2'b11, 1, 1, 1,  0, 10'h02B, 0, 2'b00, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ev, tbl[i].epc, tbl[i].ectr, tbl[i].rv, tbl[i].rt, tbl[i].fl);
      step();
      chk($sformatf("v%0d upd_valid", i),      32'(bus.upd_valid),      32'(tbl[i].xuv));
      chk($sformatf("v%0d upd_pc", i),         32'(bus.upd_pc),         32'(tbl[i].xpc));
      chk($sformatf("v%0d upd_taken", i),      32'(bus.upd_taken),      32'(tbl[i].xt));
      chk($sformatf("v%0d upd_counter", i),    32'(bus.upd_counter),    32'(tbl[i].xc));
      chk($sformatf("v%0d upd_mispredict", i), 32'(bus.upd_mispredict), 32'(tbl[i].xm));
      chk($sformatf("v%0d res_err", i),        32'(bus.res_err),        32'(tbl[i].xerr));
      chk($sformatf("v%0d occupancy", i),      32'(bus.occupancy),      32'(tbl[i].xocc));
      chk($sformatf("v%0d enq_ready", i),      32'(bus.enq_ready),      32'(tbl[i].xrdy));
    end

    // fill to full, then a dropped 9th enqueue, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 10'(i), 2'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("full occupancy", 32'(bus.occupancy), 32'd8);
    chk("full enq_ready", 32'(bus.enq_ready), 32'd0);
    drive(1'b1, 10'h099, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    chk("drop occupancy", 32'(bus.occupancy), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 10'h0, 2'b00, 1'b1, 1'(i), 1'b0);
      step();
      chk($sformatf("drain%0d upd_valid", i), 32'(bus.upd_valid), 32'd1);
      chk($sformatf("drain%0d upd_pc", i),    32'(bus.upd_pc),    32'(i));
      chk($sformatf("drain%0d upd_counter", i), 32'(bus.upd_counter), 32'(i % 4));
      chk($sformatf("drain%0d upd_mispredict", i), 32'(bus.upd_mispredict),
          32'(((i >> 1) & 1) ^ (i & 1)));
    end
    chk("drain occupancy", 32'(bus.occupancy), 32'd0);
    chk("drain enq_ready", 32'(bus.enq_ready), 32'd1);

    // pointer wrap: 6 in, 4 out, 6 more in, all 8 out
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 10'(i), 2'b01, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 10'h0, 2'b00, 1'b1, 1'b1, 1'b0);
      step();
      chk($sformatf("wrapA%0d upd_pc", i), 32'(bus.upd_pc), 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 10'(16 + i), 2'b10, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("wrap occupancy", 32'(bus.occupancy), 32'd8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 10'h0, 2'b00, 1'b1, 1'b0, 1'b0);
      step();
      chk($sformatf("wrapB%0d upd_pc", i), 32'(bus.upd_pc),
          (i < 2) ? 32'(4 + i) : 32'(16 + i - 2));
      chk($sformatf("wrapB%0d upd_valid", i), 32'(bus.upd_valid), 32'd1);
    end
    chk("wrap empty", 32'(bus.occupancy), 32'd0);

    // steady-state enqueue+resolve at occupancy 3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'(256 + i), 2'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 10'(259 + i), 2'(i + 3), 1'b1, 1'(i), 1'b0);
      step();
      chk($sformatf("sim%0d occupancy", i), 32'(bus.occupancy), 32'd3);
      chk($sformatf("sim%0d upd_pc", i),    32'(bus.upd_pc),    32'(256 + i));
      chk($sformatf("sim%0d upd_mispredict", i), 32'(bus.upd_mispredict),
          32'(((i >> 1) & 1) ^ (i & 1)));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 10'h0, 2'b00, 1'b1, 1'b0, 1'b0);
      step();
      chk($sformatf("simdrain%0d upd_pc", i), 32'(bus.upd_pc), 32'(276 + i));
    end
    chk("sim empty", 32'(bus.occupancy), 32'd0);

    // flush at occupancy 5 with concurrent enqueue and resolve
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'(64 + i), 2'b11, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("preflush occupancy", 32'(bus.occupancy), 32'd5);
    drive(1'b1, 10'h3AA, 2'b00, 1'b1, 1'b1, 1'b1);
    step();
    chk("flush occupancy", 32'(bus.occupancy), 32'd0);
    chk("flush upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("flush res_err",   32'(bus.res_err),   32'd0);
    idle();
    step();
    chk("postflush upd_valid", 32'(bus.upd_valid), 32'd0);

    // asynchronous reset while an update strobe is active
    drive(1'b1, 10'h111, 2'b10, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 10'h222, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 10'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    step();
    chk("prereset upd_valid", 32'(bus.upd_valid), 32'd1);
    chk("prereset upd_pc",    32'(bus.upd_pc),    32'h111);
    idle();
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("postreset upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("postreset occupancy", 32'(bus.occupancy), 32'd0);
    drive(1'b0, 10'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    step();
    chk("postreset res_err",   32'(bus.res_err),   32'd1);
    chk("postreset no strobe", 32'(bus.upd_valid), 32'd0);
    idle();
    step();
    chk("postreset err pulse", 32'(bus.res_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
